// File: rtl/demux_1_to_4_reg.sv
// demux_1_to_4_reg
//   Routes one producer word into one of four registered output slots.
//   Each slot is either EMPTY or FULL. An accepted write loads the slot and
//   marks it FULL. A consumer ack on a FULL slot empties it. A write to a
//   slot takes priority over a same-cycle ack of that slot. Slot data is kept
//   after an ack and is only replaced by the next write to that slot.
//
//   Optional feature macro: DEMUX_BACKPRESSURE_EN
//     defined   : in_ready = ~out_valid[sel] | out_ack[sel]. A write to a FULL,
//                 un-acked slot stalls, and overflow is tied to 0.
//     undefined : in_ready = 1. A write to a FULL, un-acked slot overwrites
//                 the slot and sets overflow, which stays set until reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (clears data and control)
//   in_data    in   [WIDTH-1:0] producer word
//   sel        in   [1:0] destination slot
//   in_valid   in   producer write request
//   in_ready   out  write acceptance (combinational)
//   out_data   out  [4*WIDTH-1:0] slot registers, slot i at [i*WIDTH +: WIDTH]
//   out_valid  out  [3:0] per-slot FULL flag
//   out_ack    in   [3:0] per-slot consumer acknowledge
//   overflow   out  sticky flag: a FULL slot was overwritten
module demux_1_to_4_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ack,
  output logic               overflow
);

  logic [WIDTH-1:0] data_p1 [4];
  logic [3:0]       vld_p1;
  logic             accept;
  logic [3:0]       wr_hit;
  logic [3:0]       vld_nxt;

`ifdef DEMUX_BACKPRESSURE_EN
  // Stall only when the target slot is FULL and not being drained this cycle.
  assign in_ready = ~vld_p1[sel] | out_ack[sel];
  assign overflow = 1'b0;
`else
  logic ovf_p1;
  logic ovf_set;

  assign in_ready = 1'b1;
  // An overwrite is a write to a FULL slot that is not emptied in the same cycle.
  assign ovf_set  = accept & vld_p1[sel] & ~out_ack[sel];
  assign overflow = ovf_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_p1 <= 1'b0;
    end else if (ovf_set) begin
      ovf_p1 <= 1'b1;
    end
  end
`endif

  assign accept = in_valid & in_ready;

  // A write sets its slot FULL and wins over an ack of that slot; acks on
  // EMPTY slots have no effect since they can only clear an already-clear bit.
  always_comb begin
    wr_hit  = 4'b0000;
    vld_nxt = vld_p1;
    if (accept) begin
      wr_hit = 4'b0001 << sel;
    end
    for (int i = 0; i < 4; i++) begin
      vld_nxt[i] = wr_hit[i] | (vld_p1[i] & ~out_ack[i]);
    end
  end

  // Stage p1: slot registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= vld_nxt;
      for (int i = 0; i < 4; i++) begin
        if (wr_hit[i]) begin
          data_p1[i] <= in_data;
        end
      end
    end
  end

  assign out_valid = vld_p1;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign out_data[g*WIDTH +: WIDTH] = data_p1[g];
  end

endmodule

// File: tb/tb_demux_1_to_4_reg.sv
// tb_demux_1_to_4_reg
//   Directed table-driven bench for demux_1_to_4_reg (WIDTH = 32). Works in
//   both builds: expectations that depend on DEMUX_BACKPRESSURE_EN are chosen
//   with the same macro.
module tb_demux_1_to_4_reg;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [1:0]     sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ack;
  logic           overflow;

  int n_total = 0;
  int n_bad   = 0;

  demux_1_to_4_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   sel;
    logic [31:0]  in_data;
    logic [3:0]   ack;
    logic         exp_ready;
    logic [3:0]   exp_valid;
    logic [127:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

`ifdef DEMUX_BACKPRESSURE_EN
  // Write of A5 to FULL slot 0 is stalled: slot keeps A0, no overflow.
  localparam logic [31:0] S0_OVW  = 32'hA0;
  localparam logic        RDY_OVW = 1'b0;
  localparam logic        OVF_OVW = 1'b0;
`else
  // Write of A5 to FULL slot 0 overwrites it and raises sticky overflow.
  localparam logic [31:0] S0_OVW  = 32'hA5;
  localparam logic        RDY_OVW = 1'b1;
  localparam logic        OVF_OVW = 1'b1;
`endif

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                              input logic [31:0] d, input logic [3:0] a,
                              input logic er, input logic [3:0] ev,
                              input logic [31:0] s3, input logic [31:0] s2,
                              input logic [31:0] s1, input logic [31:0] s0,
                              input logic eo);
    vec_t t;
    t.rst_n = r; t.in_valid = v; t.sel = s; t.in_data = d; t.ack = a;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = {s3, s2, s1, s0};
    t.exp_ovf = eo;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    // rst_n, vld, sel, data, ack | ready, valid, slot3, slot2, slot1, slot0, ovf
    // reset with write and acks pending: everything discarded
    vecs[0]  = mk(0, 1, 2'd0, 32'hFFFF,     4'hF, 1,       4'b0000, 0, 0, 0, 0, 0);
    // first edge out of reset accepts a write
    vecs[1]  = mk(1, 1, 2'd2, 32'hDEADBEEF, 4'h0, 1,       4'b0100, 0, 32'hDEADBEEF, 0, 0, 0);
    vecs[2]  = mk(1, 1, 2'd1, 32'h11111111, 4'h0, 1,       4'b0110, 0, 32'hDEADBEEF, 32'h11111111, 0, 0);
    // ack slot 1 only: empties it, data retained, slot 2 untouched
    vecs[3]  = mk(1, 0, 2'd0, 32'h0,        4'h2, 1,       4'b0100, 0, 32'hDEADBEEF, 32'h11111111, 0, 0);
    vecs[4]  = mk(1, 1, 2'd3, 32'h1,        4'h0, 1,       4'b1100, 32'h1, 32'hDEADBEEF, 32'h11111111, 0, 0);
    // write and ack same full slot: write wins, no overflow
    vecs[5]  = mk(1, 1, 2'd3, 32'h2,        4'h8, 1,       4'b1100, 32'h2, 32'hDEADBEEF, 32'h11111111, 0, 0);
    vecs[6]  = mk(1, 1, 2'd0, 32'hA0,       4'h0, 1,       4'b1101, 32'h2, 32'hDEADBEEF, 32'h11111111, 32'hA0, 0);
    // write to full slot 0 without ack
    vecs[7]  = mk(1, 1, 2'd0, 32'hA5,       4'h0, RDY_OVW, 4'b1101, 32'h2, 32'hDEADBEEF, 32'h11111111, S0_OVW, OVF_OVW);
    // write slot 1 while acking slot 2
    vecs[8]  = mk(1, 1, 2'd1, 32'h33,       4'h4, 1,       4'b1011, 32'h2, 32'hDEADBEEF, 32'h33, S0_OVW, OVF_OVW);
    // ack all full slots at once
    vecs[9]  = mk(1, 0, 2'd0, 32'h0,        4'hF, 1,       4'b0000, 32'h2, 32'hDEADBEEF, 32'h33, S0_OVW, OVF_OVW);
    // ack all with every slot empty: no change
    vecs[10] = mk(1, 0, 2'd2, 32'h0,        4'hF, 1,       4'b0000, 32'h2, 32'hDEADBEEF, 32'h33, S0_OVW, OVF_OVW);
    // data without in_valid is ignored
    vecs[11] = mk(1, 0, 2'd2, 32'h44,       4'h0, 1,       4'b0000, 32'h2, 32'hDEADBEEF, 32'h33, S0_OVW, OVF_OVW);
    vecs[12] = mk(1, 1, 2'd0, 32'h10,       4'h0, 1,       4'b0001, 32'h2, 32'hDEADBEEF, 32'h33, 32'h10, OVF_OVW);
    vecs[13] = mk(1, 1, 2'd1, 32'h20,       4'h0, 1,       4'b0011, 32'h2, 32'hDEADBEEF, 32'h20, 32'h10, OVF_OVW);
    vecs[14] = mk(1, 1, 2'd2, 32'h30,       4'h0, 1,       4'b0111, 32'h2, 32'h30, 32'h20, 32'h10, OVF_OVW);
    vecs[15] = mk(1, 1, 2'd3, 32'h40,       4'h0, 1,       4'b1111, 32'h40, 32'h30, 32'h20, 32'h10, OVF_OVW);
    // all full, reset with write and acks: all cleared
    vecs[16] = mk(0, 1, 2'd1, 32'h99,       4'hF, 1,       4'b0000, 0, 0, 0, 0, 0);
    // first write after reset, acks on empty slots ignored
    vecs[17] = mk(1, 1, 2'd3, 32'h55,       4'hF, 1,       4'b1000, 32'h55, 0, 0, 0, 0);

    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; in_data = '0; out_ack = 4'h0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      in_valid = vecs[i].in_valid;
      sel      = vecs[i].sel;
      in_data  = vecs[i].in_data;
      out_ack  = vecs[i].ack;
      #1;
      check($sformatf("v%0d in_ready", i), {127'b0, in_ready}, {127'b0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {124'b0, out_valid}, {124'b0, vecs[i].exp_valid});
      check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("v%0d overflow", i), {127'b0, overflow}, {127'b0, vecs[i].exp_ovf});
    end

    // Latency: a write is not visible before its edge, and is after it.
    @(negedge clk);
    in_valid = 1'b1; sel = 2'd0; in_data = 32'h77; out_ack = 4'h0;
    #1;
    check("lat pre valid", {124'b0, out_valid}, {124'b0, 4'b1000});
    check("lat pre data", out_data, {32'h55, 32'h0, 32'h0, 32'h0});
    @(posedge clk);
    #1;
    check("lat post valid", {124'b0, out_valid}, {124'b0, 4'b1001});
    check("lat post data", out_data, {32'h55, 32'h0, 32'h0, 32'h77});

    // Holding in_valid low keeps the state for several cycles.
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'hBAD;
    repeat (3) @(posedge clk);
    #1;
    check("hold valid", {124'b0, out_valid}, {124'b0, 4'b1001});
    check("hold data", out_data, {32'h55, 32'h0, 32'h0, 32'h77});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
